// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order circular FIFO that drains to data memory one
// entry per accepted cycle, with youngest-match store-to-load forwarding and a fence FSM.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       st_valid,
  input  logic [AW-1:0]              st_addr,
  input  logic [DW-1:0]              st_data,
  output logic                       st_ready,
  input  logic                       ld_valid,
  input  logic [AW-1:0]              ld_addr,
  output logic                       ld_hit,
  output logic [DW-1:0]              ld_data,
  output logic                       mem_we,
  output logic [AW-1:0]              mem_addr,
  output logic [DW-1:0]              mem_wdata,
  input  logic                       mem_ready,
  input  logic                       flush,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, DRAIN} state_t;

  logic [AW-3:0] ent_addr [DEPTH];
  logic [DW-1:0] ent_data [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt_nxt;
  logic [PW-1:0] idx;
  logic          push;
  logic          pop;
  logic          flush_pending;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  state_t        state;

  // Sub-word address bits play no part in whole-word matching or storage.
  logic unused_ok;
  assign unused_ok = ^{st_addr[1:0], ld_addr[1:0]};

  assign empty         = (count == '0);
  assign mem_we        = !empty;
  assign mem_addr      = {ent_addr[rd_ptr], 2'b00};
  assign mem_wdata     = ent_data[rd_ptr];
  assign flush_pending = (state == DRAIN) || (flush && !empty);
  assign st_ready      = (count != CW'(DEPTH)) && !flush_pending;
  assign push          = st_valid && st_ready;
  assign pop           = mem_we && mem_ready;

  always_comb begin
    cnt_nxt = count;
    case ({push, pop})
      2'b10:   cnt_nxt = count + 1'b1;
      2'b01:   cnt_nxt = count - 1'b1;
      default: cnt_nxt = count;
    endcase
  end

  // Walk oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if ((CW'(k) < count) && (ent_addr[idx] == ld_addr[AW-1:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data[idx];
      end
    end
  end

  assign ld_hit  = ld_valid && fwd_hit;
  assign ld_data = fwd_data;

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[wr_ptr] <= st_addr[AW-1:2];
      ent_data[wr_ptr] <= st_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= IDLE;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= cnt_nxt;
      case (state)
        IDLE:    if (flush && !empty) state <= DRAIN;
        DRAIN:   if (cnt_nxt == '0)   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the pipelined core's memory stage and the data memory. Stores retire into a small in-order FIFO so the core does not wait on memory; entries drain to data memory one per accepted cycle. Loads check the buffer combinationally, and the youngest matching store's data is forwarded so a load never sees stale memory.

## Interface
Parameters:
- DEPTH, 4: number of entries; power of two, at least 2.
- AW, 32: address width.
- DW, 32: data width; whole-word stores only.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- st_valid  input  1  core presents a store this cycle.
- st_addr  input  AW  store byte address; bits [1:0] are ignored.
- st_data  input  DW  store data.
- st_ready  output  1  buffer can accept a store; the core stalls its memory stage when this is low.
- ld_valid  input  1  core presents a load this cycle.
- ld_addr  input  AW  load byte address; bits [1:0] are ignored.
- ld_hit  output  1  a buffered store matches ld_addr.
- ld_data  output  DW  forwarded data; valid only when ld_hit is high.
- mem_we  output  1  write request to data memory.
- mem_addr  output  AW  head-entry address, with bits [1:0] forced to 0.
- mem_wdata  output  DW  head-entry data.
- mem_ready  input  1  memory accepts the write this cycle.
- flush  input  1  fence request; blocks new stores until the buffer is empty.
- empty  output  1  buffer holds no entries.
- count  output  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- Storage is a circular FIFO with wr_ptr and rd_ptr, each $clog2(DEPTH) bits wide and wrapping modulo DEPTH. A separate occupancy counter holds the count.
- Push: on a rising edge with st_valid && st_ready, write {st_addr[AW-1:2], st_data} at wr_ptr, then increment wr_ptr.
- Pop: on a rising edge with mem_we && mem_ready, increment rd_ptr.
- mem_we = !empty. mem_addr and mem_wdata come directly from the head entry; there is no output register.
- st_ready = (count != DEPTH) && !flush_pending.
  - st_ready ignores a pop in the same cycle, so a full buffer refuses a store even while draining.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Forwarding:
  - Compare ld_addr[AW-1:2] against every occupied entry.
  - ld_hit = ld_valid && any match.
  - ld_data comes from the youngest matching entry, i.e. the one closest to wr_ptr-1 going backwards.
  - The head entry being popped in the current cycle is still eligible to match.
  - A store pushed in the same cycle is not visible to a load in that cycle.
- Duplicate addresses are kept as separate entries; there is no coalescing. Memory receives the writes in program order.
- Flush FSM, with states IDLE and DRAIN:
  - IDLE -> DRAIN when flush is high and the buffer is not empty.
  - DRAIN -> IDLE on the edge where count becomes 0.
  - flush_pending is high in DRAIN, and also combinationally while flush is high and the buffer is not empty.
  - flush with an empty buffer has no effect.
- Reset (asserted low, asynchronous) clears both pointers, count, and the FSM to IDLE. Entry contents are don't-care.
  - After reset: empty=1, count=0, mem_we=0, st_ready=1, ld_hit=0.
  - Reset during DRAIN discards the remaining entries. Those writes are lost, and this is accepted behaviour.

## Timing
- Store-to-memory latency: a store pushed at edge N drives mem_we in cycle N+1 if the buffer was empty. The earliest memory write is therefore at edge N+1, given mem_ready.
- Drain throughput: one entry per cycle while mem_ready is held high.
- ld_hit and ld_data are combinational from ld_addr and the current entries, with zero-cycle latency.
- st_ready, empty, count, and mem_* are functions of registered state only; flush alone affects st_ready combinationally. There is no path from st_valid to st_ready.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble.
- Full and empty are distinguished by count, not by pointer equality.

## Test plan
- Reset then idle:
  - reset low for 2 cycles, then high -> empty=1, count=0, mem_we=0, st_ready=1.
- Single store:
  - Push addr 0x10, data 0xDEADBEEF with mem_ready=1 -> next cycle mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF.
  - The cycle after that -> empty=1.
- Fill and backpressure:
  - mem_ready=0 and 5 consecutive stores to 0x0, 0x4, 0x8, 0xC, 0x10 -> the first 4 are accepted, count=4, st_ready=0 and the 5th is held.
  - Raise mem_ready -> writes leave in order 0x0, 0x4, 0x8, 0xC, and the 5th store is accepted the cycle after the first pop.
- Forwarding, youngest wins:
  - With mem_ready=0, store 0x20=0x11, then 0x24=0x22, then 0x20=0x33.
  - Load 0x22 (bits [1:0] ignored) -> ld_hit=1, ld_data=0x33.
  - Load 0x28 -> ld_hit=0.
- Simultaneous push/pop with wrap-around:
  - mem_ready=1 and a store every cycle for 10 cycles -> count stays 1, pointers wrap, and memory sees all 10 writes in order.
- Flush and mid-drain reset:
  - Flush with 3 entries and mem_ready=1 -> st_ready=0 for 3 cycles, then empty=1 and st_ready=1.
  - Repeat, but pulse reset low after the first pop -> count=0 and mem_we=0 immediately, with no further memory writes.
